seq_ctrl: RTL and testbench
===========================

SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: maximum sequence length (1..16); reaching it wins the game.
REQ-002 SHALL have parameter SHOW_CYCLES, default 4: cycles each stored colour is shown.
REQ-003 SHALL have parameter GAP_CYCLES, default 2: blank cycles after each shown colour.
REQ-004 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  begin a new game; sampled only when busy=0.
REQ-007 SHALL have port rand_num  in  2  colour appended to the sequence each round.
REQ-008 SHALL have port btn_valid  in  1  one-cycle pulse: player pressed a button.
REQ-009 SHALL have port btn_num  in  2  pressed colour, qualified by btn_valid.
REQ-010 SHALL have port mem_address  out  4  address to the sequence memory.
REQ-011 SHALL have port mem_rw  out  1  1 = write mem_in_num at mem_address this edge; 0 = read.
REQ-012 SHALL have port mem_in_num  out  2  write data to the memory.
REQ-013 SHALL have port mem_out_num  in  2  read data; valid one cycle after mem_address is applied with mem_rw=0.
REQ-014 SHALL have port show_valid  out  1  colour on show_num is being displayed.
REQ-015 SHALL have port show_num  out  2  colour being displayed.
REQ-016 SHALL have port level  out  4  current sequence length minus 1 (0 in IDLE).
REQ-017 SHALL have port busy  out  1  game in progress (any state except IDLE/WIN/LOSE).
REQ-018 SHALL have port win  out  1  held high in WIN.
REQ-019 SHALL have port lose  out  1  held high in LOSE.

Function
REQ-020 SHALL implement FSM states IDLE, APPEND, SHOW_RD, SHOW, GAP, IN_RD, IN_WAIT, WIN, LOSE; outputs registered.
REQ-021 SHALL keep length counter len (5 bits) and index counter idx (4 bits).
REQ-022 IDLE/WIN/LOSE: start=1 SHALL clear len to 0, clear win/lose, go to APPEND next cycle.
REQ-023 APPEND (1 cycle): mem_rw=1, mem_address=len, mem_in_num=rand_num; len<=len+1, idx<=0; next SHOW_RD.
REQ-024 SHOW_RD (2 cycles): mem_rw=0, mem_address=idx; mem_out_num SHALL be latched into show_num at end of 2nd cycle; next SHOW.
REQ-025 SHOW: show_valid=1 for exactly SHOW_CYCLES cycles, then GAP.
REQ-026 GAP: show_valid=0 for GAP_CYCLES cycles; then idx<=idx+1 and go SHOW_RD, or if idx+1==len, idx<=0 and go IN_RD.
REQ-027 IN_RD (2 cycles): mem_rw=0, mem_address=idx; expected colour latched internally; next IN_WAIT.
REQ-028 IN_WAIT: wait indefinitely for btn_valid; btn_num!=expected -> LOSE.
REQ-029 IN_WAIT match: if idx+1<len, idx++ and go IN_RD; else if len==MAX_LEN go WIN; else go APPEND.
REQ-030 btn_valid outside IN_WAIT SHALL be ignored; start while busy=1 SHALL be ignored.
REQ-031 mem_rw SHALL be 1 only in APPEND; at most one write per round; no write beyond address MAX_LEN-1.
REQ-032 level SHALL equal len-1 while len>0, held through WIN/LOSE until next start.
REQ-033 show_valid SHALL be 0 in every state except SHOW.

Reset
REQ-034 reset=1 at a rising edge SHALL force IDLE from any state, mid-show or mid-input included.
REQ-035 Reset values: all outputs 0, len=0, idx=0, show_num=0, mem_rw=0, mem_address=0, mem_in_num=0.
REQ-036 reset SHALL take priority over start and btn_valid in the same cycle.

Verification
REQ-037 Test parameters: MAX_LEN=3, SHOW_CYCLES=2, GAP_CYCLES=1; behavioural mem with 1-cycle read latency.
REQ-038 start at cycle 0, rand_num=2 -> cycle 1 mem_rw=1, mem_address=0, mem_in_num=2; show_valid high 2 cycles, show_num=2; then IN_WAIT with busy=1, level=0.
REQ-039 rand_num 2,1,3 across rounds, correct presses every round -> after third round's last press, win=1, busy=0, level=2; exactly 3 writes at addresses 0,1,2.
REQ-040 round 2 (sequence 2,1), press 2 then 3 -> lose=1, busy=0, level=1, no further memory writes.
REQ-041 reset asserted during SHOW of round 2 -> next cycle IDLE, all outputs 0; later start begins at address 0 with level=0.
REQ-042 btn_valid pulsed during SHOW/GAP and start pulsed while busy -> no state change; displayed sequence and level unchanged.

Source files
------------

// File: rtl/seq_ctrl.sv
// -----------------------------------------------------------------------------
// seq_ctrl : colour-sequence memory game controller.
//
// Each round appends one random colour to an external sequence memory, replays
// the whole stored sequence (SHOW_CYCLES on, GAP_CYCLES blank per colour), then
// checks the player's button presses against memory in order. A wrong press
// loses; matching a full sequence of MAX_LEN colours wins.
//
// Ports
//   clock, reset     : sole clock, synchronous active-high reset
//   start            : begin a new game (ignored while busy)
//   rand_num[1:0]    : colour appended this round (sampled entering APPEND)
//   btn_valid/btn_num: one-cycle button press and its colour
//   mem_address[3:0] : sequence memory address
//   mem_rw           : 1 = write mem_in_num this edge, 0 = read
//   mem_in_num[1:0]  : memory write data
//   mem_out_num[1:0] : memory read data, one cycle after the address
//   show_valid/show_num : colour being displayed
//   level[3:0]       : sequence length minus one
//   busy, win, lose  : game status
//
// All outputs are registers loaded from the next-state values, so every
// output reflects the state being entered at each edge.
// -----------------------------------------------------------------------------
module seq_ctrl #(
    parameter int MAX_LEN     = 16,
    parameter int SHOW_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] rand_num,
    input  logic       btn_valid,
    input  logic [1:0] btn_num,
    output logic [3:0] mem_address,
    output logic       mem_rw,
    output logic [1:0] mem_in_num,
    input  logic [1:0] mem_out_num,
    output logic       show_valid,
    output logic [1:0] show_num,
    output logic [3:0] level,
    output logic       busy,
    output logic       win,
    output logic       lose
);

    // Phase counter must cover the 2-cycle reads as well as show/gap spans.
    localparam int CNT_MAX = (SHOW_CYCLES > GAP_CYCLES) ?
                             ((SHOW_CYCLES > 2) ? SHOW_CYCLES : 2) :
                             ((GAP_CYCLES  > 2) ? GAP_CYCLES  : 2);
    localparam int CW = $clog2(CNT_MAX);

    localparam logic [CW-1:0] RD_LAST   = CW'(1);
    localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [4:0]    LEN_MAX   = 5'(MAX_LEN);

    typedef enum logic [3:0] {
        S_IDLE,
        S_APPEND,
        S_SHOW_RD,
        S_SHOW,
        S_GAP,
        S_IN_RD,
        S_IN_WAIT,
        S_WIN,
        S_LOSE
    } state_t;

    // state and counters
    state_t        r_state;
    logic [4:0]    r_len;
    logic [3:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_exp;

    // registered outputs
    logic [3:0]    r_mem_address;
    logic          r_mem_rw;
    logic [1:0]    r_mem_in_num;
    logic          r_show_valid;
    logic [1:0]    r_show_num;
    logic [3:0]    r_level;
    logic          r_busy;
    logic          r_win;
    logic          r_lose;

    // next-state values
    state_t        w_state;
    logic [4:0]    w_len;
    logic [3:0]    w_idx;
    logic [CW-1:0] w_cnt;
    logic [1:0]    w_exp;
    logic [3:0]    w_mem_address;
    logic          w_mem_rw;
    logic [1:0]    w_mem_in_num;
    logic          w_show_valid;
    logic [1:0]    w_show_num;
    logic [3:0]    w_level;
    logic          w_busy;
    logic          w_win;
    logic          w_lose;

    // idx+1 widened to compare against the 5-bit length
    logic [4:0]    w_idx_inc;
    assign w_idx_inc = {1'b0, r_idx} + 5'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_exp         <= '0;
            r_mem_address <= '0;
            r_mem_rw      <= 1'b0;
            r_mem_in_num  <= '0;
            r_show_valid  <= 1'b0;
            r_show_num    <= '0;
            r_level       <= '0;
            r_busy        <= 1'b0;
            r_win         <= 1'b0;
            r_lose        <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_len         <= w_len;
            r_idx         <= w_idx;
            r_cnt         <= w_cnt;
            r_exp         <= w_exp;
            r_mem_address <= w_mem_address;
            r_mem_rw      <= w_mem_rw;
            r_mem_in_num  <= w_mem_in_num;
            r_show_valid  <= w_show_valid;
            r_show_num    <= w_show_num;
            r_level       <= w_level;
            r_busy        <= w_busy;
            r_win         <= w_win;
            r_lose        <= w_lose;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_len      = r_len;
        w_idx      = r_idx;
        w_cnt      = r_cnt;
        w_exp      = r_exp;
        w_show_num = r_show_num;

        case (r_state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    w_len   = '0;
                    w_idx   = '0;
                    w_cnt   = '0;
                    w_state = S_APPEND;
                end
            end

            S_APPEND: begin
                w_len   = r_len + 5'd1;
                w_idx   = '0;
                w_cnt   = '0;
                w_state = S_SHOW_RD;
            end

            // Cycle 0 presents the address, cycle 1 sees the read data.
            S_SHOW_RD: begin
                if (r_cnt == RD_LAST) begin
                    w_show_num = mem_out_num;
                    w_cnt      = '0;
                    w_state    = S_SHOW;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end

            S_SHOW: begin
                if (r_cnt == SHOW_LAST) begin
                    w_cnt   = '0;
                    w_state = S_GAP;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end

            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt = '0;
                    if (w_idx_inc == r_len) begin
                        w_idx   = '0;
                        w_state = S_IN_RD;
                    end else begin
                        w_idx   = r_idx + 4'd1;
                        w_state = S_SHOW_RD;
                    end
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end

            S_IN_RD: begin
                if (r_cnt == RD_LAST) begin
                    w_exp   = mem_out_num;
                    w_cnt   = '0;
                    w_state = S_IN_WAIT;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end

            S_IN_WAIT: begin
                if (btn_valid) begin
                    if (btn_num != r_exp) begin
                        w_state = S_LOSE;
                    end else if (w_idx_inc < r_len) begin
                        w_idx   = r_idx + 4'd1;
                        w_state = S_IN_RD;
                    end else if (r_len == LEN_MAX) begin
                        w_state = S_WIN;
                    end else begin
                        w_state = S_APPEND;
                    end
                end
            end

            default: w_state = S_IDLE;
        endcase

        // Outputs follow the state being entered.
        w_mem_rw      = (w_state == S_APPEND);
        w_mem_in_num  = (w_state == S_APPEND) ? rand_num : 2'd0;
        w_mem_address = 4'd0;
        if (w_state == S_APPEND)
            w_mem_address = w_len[3:0];
        else if (w_state == S_SHOW_RD || w_state == S_IN_RD)
            w_mem_address = w_idx;

        w_show_valid = (w_state == S_SHOW);
        w_busy       = !(w_state == S_IDLE || w_state == S_WIN || w_state == S_LOSE);
        w_win        = (w_state == S_WIN);
        w_lose       = (w_state == S_LOSE);
        // len of 16 wraps the low nibble to 0, and 0-1 still gives 15.
        w_level      = (w_len == 5'd0) ? 4'd0 : (w_len[3:0] - 4'd1);
    end

    assign mem_address = r_mem_address;
    assign mem_rw      = r_mem_rw;
    assign mem_in_num  = r_mem_in_num;
    assign show_valid  = r_show_valid;
    assign show_num    = r_show_num;
    assign level       = r_level;
    assign busy        = r_busy;
    assign win         = r_win;
    assign lose        = r_lose;

endmodule

// File: tb/tb_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_ctrl : directed bench for seq_ctrl with MAX_LEN=3, SHOW_CYCLES=2,
// GAP_CYCLES=1. A game model expands each round into a per-cycle script of
// expected outputs; a negedge process compares the DUT to it every cycle.
// Hand-computed literal checks pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_seq_ctrl;
    localparam int ML = 3;
    localparam int SC = 2;
    localparam int GC = 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] rand_num = 2'd0;
    logic       btn_valid = 1'b0;
    logic [1:0] btn_num = 2'd0;
    logic [3:0] mem_address;
    logic       mem_rw;
    logic [1:0] mem_in_num;
    logic [1:0] mem_out_num = 2'd0;
    logic       show_valid;
    logic [1:0] show_num;
    logic [3:0] level;
    logic       busy, win, lose;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    seq_ctrl #(.MAX_LEN(ML), .SHOW_CYCLES(SC), .GAP_CYCLES(GC)) dut (
        .clock(clock), .reset(reset), .start(start), .rand_num(rand_num),
        .btn_valid(btn_valid), .btn_num(btn_num),
        .mem_address(mem_address), .mem_rw(mem_rw), .mem_in_num(mem_in_num),
        .mem_out_num(mem_out_num), .show_valid(show_valid), .show_num(show_num),
        .level(level), .busy(busy), .win(win), .lose(lose)
    );

    // behavioural memory, 1-cycle read latency, with a write log
    logic [1:0] mem [16];
    int wr_cnt = 0;
    int wr_addr[$];
    initial for (int i = 0; i < 16; i++) mem[i] = 2'd0;
    always @(posedge clock) begin
        if (mem_rw) begin
            mem[mem_address] <= mem_in_num;
            wr_cnt++;
            wr_addr.push_back(int'(mem_address));
        end
        mem_out_num <= mem[mem_address];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- game model ----------------
    typedef struct {
        bit rw; int addr; bit ca; int din; bit cd;
        bit sv; int sn; bit busy; int lvl; bit win; bit lose;
    } exp_t;

    localparam int M_IDLE = 0, M_PLAY = 1, M_WIN = 2, M_LOSE = 3;
    exp_t cur;
    exp_t scr[$];
    int   seq[$];
    int   pi = 0;
    int   mode = M_IDLE;
    bit   m_wait = 0;
    bit   m_init = 0;

    task automatic push_rd(input int a, input int s, input int lv);
        exp_t e;
        e = '{default: 0};
        e.addr = a; e.ca = 1; e.sn = s; e.busy = 1; e.lvl = lv;
        scr.push_back(e);
    endtask

    // One round: append, then (read, show, gap) per colour, then read colour 0.
    task automatic build_round();
        int L;
        int s;
        exp_t e;
        L = seq.size();
        s = cur.sn;
        e = '{default: 0};
        e.rw = 1; e.addr = L - 1; e.ca = 1; e.din = seq[L-1]; e.cd = 1;
        e.sn = s; e.busy = 1; e.lvl = (L - 1 == 0) ? 0 : L - 2;
        scr.push_back(e);
        for (int k = 0; k < L; k++) begin
            push_rd(k, s, L - 1);
            push_rd(k, s, L - 1);
            s = seq[k];
            for (int c = 0; c < SC + GC; c++) begin
                e = '{default: 0};
                e.sv = (c < SC); e.sn = s; e.busy = 1; e.lvl = L - 1;
                scr.push_back(e);
            end
        end
        push_rd(0, s, L - 1);
        push_rd(0, s, L - 1);
    endtask

    function automatic exp_t status(input bit b, input bit w, input bit l);
        exp_t e;
        e = '{default: 0};
        e.sn = cur.sn; e.busy = b; e.win = w; e.lose = l; e.lvl = seq.size() - 1;
        return e;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_init = 1;
            mode = M_IDLE;
            scr.delete();
            seq.delete();
            cur = '{default: 0};
            cur.ca = 1; cur.cd = 1;
            m_wait = 0;
        end else if (mode != M_PLAY) begin
            if (start) begin
                seq.delete();
                seq.push_back(int'(rand_num));
                pi = 0;
                mode = M_PLAY;
                build_round();
                cur = scr.pop_front();
                m_wait = 0;
            end
        end else if (m_wait && btn_valid) begin
            m_wait = 0;
            if (int'(btn_num) != seq[pi]) begin
                mode = M_LOSE;
                cur = status(0, 0, 1);
            end else if (pi + 1 < seq.size()) begin
                pi++;
                push_rd(pi, cur.sn, seq.size() - 1);
                push_rd(pi, cur.sn, seq.size() - 1);
                cur = scr.pop_front();
            end else if (seq.size() == ML) begin
                mode = M_WIN;
                cur = status(0, 1, 0);
            end else begin
                seq.push_back(int'(rand_num));
                pi = 0;
                build_round();
                cur = scr.pop_front();
            end
        end else if (scr.size() > 0) begin
            cur = scr.pop_front();
            m_wait = 0;
        end else begin
            cur = status(1, 0, 0);
            m_wait = 1;
        end
    end

    always @(negedge clock) begin
        if (m_init) begin
            chk("mem_rw", mem_rw, cur.rw);
            if (cur.ca) chk("mem_address", mem_address, cur.addr);
            if (cur.cd) chk("mem_in_num", mem_in_num, cur.din);
            chk("show_valid", show_valid, cur.sv);
            chk("show_num", show_num, cur.sn);
            chk("busy", busy, cur.busy);
            chk("level", level, cur.lvl);
            chk("win", win, cur.win);
            chk("lose", lose, cur.lose);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_in_wait();
        int n = 0;
        while (!m_wait && n < 200) begin tick(); n++; end
        if (!m_wait) chk("in_wait_timeout", m_wait, 1);
    endtask

    task automatic wait_show();
        int n = 0;
        while (!show_valid && n < 200) begin tick(); n++; end
        if (!show_valid) chk("show_timeout", show_valid, 1);
    endtask

    task automatic press(input logic [1:0] c);
        wait_in_wait();
        btn_valid = 1'b1;
        btn_num = c;
        tick();
        btn_valid = 1'b0;
    endtask

    initial begin
        int nsv;
        int snv;
        int wb;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // first round: write at cycle 1, show colour 2 for two cycles
        rand_num = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("r1_wr_rw", mem_rw, 1);
        chk("r1_wr_addr", mem_address, 0);
        chk("r1_wr_data", mem_in_num, 2);
        nsv = 0; snv = 0;
        repeat (10) begin
            tick();
            if (show_valid) begin nsv++; snv = int'(show_num); end
        end
        chk("r1_show_len", nsv, 2);
        chk("r1_show_num", snv, 2);
        wait_in_wait();
        chk("r1_wait_busy", busy, 1);
        chk("r1_wait_level", level, 0);

        // round 2 with stray button/start during show and gap
        rand_num = 2'd1;
        press(2'd2);
        wait_show();
        btn_valid = 1'b1; btn_num = 2'd0; start = 1'b1;
        tick();
        btn_valid = 1'b0; start = 1'b0;
        tick();
        chk("r2_gap_sv", show_valid, 0);
        btn_valid = 1'b1; btn_num = 2'd3;
        tick();
        btn_valid = 1'b0;
        chk("r2_level", level, 1);
        chk("r2_busy", busy, 1);
        press(2'd2);
        rand_num = 2'd3;
        press(2'd1);

        // round 3 to win
        press(2'd2);
        press(2'd1);
        press(2'd3);
        chk("win_win", win, 1);
        chk("win_busy", busy, 0);
        chk("win_level", level, 2);
        chk("win_lose", lose, 0);
        chk("win_writes", wr_cnt, 3);
        chk("win_addr0", wr_addr.size() > 0 ? wr_addr[0] : -1, 0);
        chk("win_addr1", wr_addr.size() > 1 ? wr_addr[1] : -1, 1);
        chk("win_addr2", wr_addr.size() > 2 ? wr_addr[2] : -1, 2);

        // lose in round 2
        wb = wr_cnt;
        rand_num = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        rand_num = 2'd1;
        press(2'd2);
        press(2'd2);
        press(2'd3);
        chk("lose_lose", lose, 1);
        chk("lose_win", win, 0);
        chk("lose_busy", busy, 0);
        chk("lose_level", level, 1);
        repeat (5) tick();
        chk("lose_writes", wr_cnt - wb, 2);

        // reset during round-2 show, with start/btn in the same cycle
        rand_num = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        rand_num = 2'd1;
        press(2'd2);
        wait_show();
        reset = 1'b1; start = 1'b1; btn_valid = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0; btn_valid = 1'b0;
        chk("rst_outputs", {mem_rw, mem_address, mem_in_num, show_valid, show_num,
                            level, busy, win, lose}, 0);
        repeat (3) tick();
        rand_num = 2'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_rw", mem_rw, 1);
        chk("restart_addr", mem_address, 0);
        chk("restart_data", mem_in_num, 3);
        chk("restart_level", level, 0);
        press(2'd3);
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
